ubpipe_cska: RTL and testbench
==============================

# ubpipe_cska

Pipelined, parametrised carry-skip adder/subtractor with a valid/ready handshake. It succeeds the fixed 27-bit, 3-bit-block combinational carry-skip adder. Width, block size and pipeline depth are parameters, and the block adds an add/subtract mode and an external carry-in. It sits in the arithmetic datapath wherever a wide unsigned adder must close timing at clock rate, with full throughput and backpressure.

## Interface
Parameters:
- `W`, 27, operand width in bits (≥ 2).
- `BLK`, 3, carry-skip block width. The last block takes the remainder `W mod BLK` if nonzero.
- `STAGES`, 3, pipeline register stages (1 ≤ STAGES ≤ number of blocks `NB = ceil(W/BLK)`).

Ports:
- `CLK`, in, 1, the single clock; all state updates on the rising edge.
- `RST`, in, 1, reset; synchronous, active-high.
- `I_VALID`, in, 1, input operands valid.
- `I_READY`, out, 1, block can accept the input this cycle.
- `X`, in, W, operand 1, unsigned.
- `Y`, in, W, operand 2, unsigned.
- `CI`, in, 1, carry-in (ignored when `SUB`=1).
- `SUB`, in, 1, 0 = X+Y+CI, 1 = X−Y (X + ~Y + 1).
- `O_VALID`, out, 1, result valid.
- `O_READY`, in, 1, downstream accepts the result.
- `S`, out, W+1, result. `S[W]` is the carry-out: borrow-free flag in subtract mode, 1 when X ≥ Y.

## Operation
- **Block assignment.** Blocks are split across stages. Stage k (0-based) holds blocks `[k*BPS, min((k+1)*BPS, NB))`, where `BPS = ceil(NB/STAGES)`. Stages that would receive no blocks are a parameter error; elaboration fails via an assertion.
- **Carry-skip block.** Ripple of propagate full adders, with `p_i = x_i ^ y_i` and `g_i = x_i & y_i`. Block carry-out = ripple carry OR (AND of all `p_i` in the block AND block carry-in). This is identical to the existing block semantics.
- **Operand preprocessing (stage 0 input).** `y' = SUB ? ~Y : Y` and `c0 = SUB ? 1 : CI`.
- **Skewing.** Operand bits consumed by stage k are delayed k register stages. Sum bits produced at stage k are delayed `STAGES-1-k` register stages. All bits of one result therefore emerge together. The inter-stage carry is registered with its stage.
- **Handshake and flow control.**
  - A single global advance: `adv = ~O_VALID | O_READY`, and `I_READY = adv`.
  - When `adv`=1, every pipeline register (data and per-stage valid bit) shifts one stage.
  - When `adv`=0, all registers hold. `S` and `O_VALID` stay stable until accepted.
  - An input is accepted on `I_VALID & I_READY`. A bubble (valid bit 0) propagates when `I_VALID`=0 during an advance.
- **Width rules.** All arithmetic is modulo 2^(W+1), with no saturation. In subtract mode, X<Y gives `S[W]`=0 and `S[W-1:0]` = X−Y mod 2^W.

## Timing
- **Latency.** Exactly `STAGES` cycles from the accepting edge to `O_VALID`=1 with the matching `S`, given `O_READY`=1 throughout.
- **Throughput.** One result per cycle when `O_READY`=1.
- **Reset.** While `RST`=1 at an edge, all valid bits, `S` and all data registers are cleared to 0. Consequently `O_VALID`=0, `S`=0 and `I_READY`=1 on the cycle after reset.
- **Reset mid-operation.** In-flight operands are discarded, and no result for them ever appears.
- **Stall boundaries.**
  - Inputs presented while `I_READY`=0 are not captured; the source must hold them.
  - On the cycle `O_READY` returns high, the held result is consumed and the pipeline advances in the same cycle. Nothing is lost or duplicated.
- **Simultaneous events.** Accept and output-consume in the same cycle is the normal full-throughput case. `RST` has priority over any handshake.
- **Combinational paths.** The only combinational path from inputs to outputs is `O_READY` → `I_READY`.
- **Critical path per stage.** About `2*BLK` full-adder delays plus `BPS-1` skip muxes.

## Structure
- **Shared package `ubcska_pkg`:**
  - function `nb(W,BLK)` returning the number of blocks;
  - function `bps(W,BLK,STAGES)` returning blocks per stage;
  - localparam-derived bit ranges for block j: `lo = j*BLK`, `hi = min(lo+BLK,W)-1`.
- **Sub-module `ubcskb_blk`**, parametrised by block width: inputs X, Y, Ci; outputs S, Co. It is purely combinational and generate-instantiated `NB` times.
- **Top level** owns the skew/deskew register arrays, valid bits and the `adv` logic.

## Test plan
Default parameters unless stated.
- **Carry ripple across all stages:** X=0x7FFFFFF, Y=0x0000001, CI=0, SUB=0 → S=0x8000000 exactly 3 cycles after accept.
- **Subtract with borrow:** X=5, Y=7, SUB=1 → S[26:0]=0x7FFFFFE, S[27]=0. Then X=7, Y=5, SUB=1 → S=0x8000002.
- **Back-to-back throughput:** 100 random (X, Y, CI, SUB) vectors on consecutive cycles with O_READY=1 → 100 consecutive O_VALID cycles, each matching the reference model, in order.
- **Backpressure:** drive O_READY=0 for 5 cycles while the pipe is full. I_READY=0 and S stays stable throughout. On release, the three results drain in order and none are dropped or duplicated.
- **Reset mid-operation:** RST=1 for one cycle with 3 results in flight → O_VALID=0 and S=0 the next cycle, and no stale result appears afterward.
- **Parameter sweep:** (W, BLK, STAGES) = (8,3,1), (16,4,4), (27,5,2), (64,8,3), each with random stimulus against the model. STAGES=1 gives latency 1, and the remainder block is exercised.

Source files
------------

// File: rtl/ubcska_pkg.sv
// Shared sizing helpers for the pipelined carry-skip adder: block count,
// blocks per pipeline stage and the bit ranges covered by blocks and stages.
package ubcska_pkg;

    function automatic int nb(input int w, input int blk);
        return (w + blk - 1) / blk;
    endfunction

    function automatic int bps(input int w, input int blk, input int stages);
        return (nb(w, blk) + stages - 1) / stages;
    endfunction

    function automatic int blk_lo(input int j, input int blk);
        return j * blk;
    endfunction

    // The last block is narrower when blk does not divide w.
    function automatic int blk_hi(input int j, input int blk, input int w);
        return (((j + 1) * blk < w) ? (j + 1) * blk : w) - 1;
    endfunction

    function automatic int stage_last_blk(input int k, input int w, input int blk, input int stages);
        int last;
        last = (k + 1) * bps(w, blk, stages) - 1;
        return (last < nb(w, blk)) ? last : nb(w, blk) - 1;
    endfunction

    function automatic int stage_lo(input int k, input int w, input int blk, input int stages);
        return blk_lo(k * bps(w, blk, stages), blk);
    endfunction

    function automatic int stage_hi(input int k, input int w, input int blk, input int stages);
        return blk_hi(stage_last_blk(k, w, blk, stages), blk, w);
    endfunction

endpackage

// File: rtl/ubcskb_blk.sv
// One carry-skip block: a ripple of full adders whose carry-out is bypassed
// by the block carry-in when every bit position propagates.
module ubcskb_blk #(
    parameter int BW = 3
) (
    input  logic [BW-1:0] X,
    input  logic [BW-1:0] Y,
    input  logic          Ci,
    output logic [BW-1:0] S,
    output logic          Co
);

    logic [BW-1:0] p;
    logic [BW-1:0] g;
    logic [BW:0]   c;

    assign p = X ^ Y;
    assign g = X & Y;

    // NOTE: every bit of c gets a value before the loop, so no latch is inferred.
    always_comb begin
        c    = '0;
        c[0] = Ci;
        for (int i = 0; i < BW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign S  = p ^ c[BW-1:0];
    assign Co = c[BW] | (&p & Ci);

endmodule

// File: rtl/ubpipe_cska.sv
// Pipelined carry-skip adder/subtractor with a valid/ready handshake.
// Operands are skewed into the stage that consumes them; sum bits are carried forward so a result emerges whole.
module ubpipe_cska
    import ubcska_pkg::*;
#(
    parameter int W      = 27,
    parameter int BLK    = 3,
    parameter int STAGES = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         I_VALID,
    output logic         I_READY,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         CI,
    input  logic         SUB,
    output logic         O_VALID,
    input  logic         O_READY,
    output logic [W:0]   S
);

    localparam int NB  = nb(W, BLK);
    localparam int BPS = bps(W, BLK, STAGES);

    if (W < 2 || STAGES < 1 || STAGES > NB || (STAGES - 1) * BPS >= NB) begin : g_param_check
        $error("ubpipe_cska: W/BLK/STAGES leave a pipeline stage without blocks");
    end

    logic [W-1:0]      op_x     [STAGES];
    logic [W-1:0]      op_y     [STAGES];
    logic [W-1:0]      sum_prev [STAGES];
    logic [W-1:0]      sum_next [STAGES];
    logic [STAGES-1:0] op_c;
    logic [STAGES-1:0] stage_co;
    logic [STAGES-1:0] v_in;

    logic [W-1:0]      x_q [STAGES];
    logic [W-1:0]      y_q [STAGES];
    logic [W-1:0]      s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    logic [W-1:0]      blk_s;
    logic              adv;
    logic [STAGES-1:0] unused_ops;
    logic              unused_tail;

    assign adv     = ~O_VALID | O_READY;
    assign I_READY = adv;
    assign O_VALID = v_q[STAGES-1];
    assign S       = {c_q[STAGES-1], s_q[STAGES-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = stage_lo(k, W, BLK, STAGES);
        localparam int HI   = stage_hi(k, W, BLK, STAGES);
        localparam int LAST = stage_last_blk(k, W, BLK, STAGES);
        localparam logic [W-1:0] MASK = ({W{1'b1}} >> (W - 1 - HI)) & ({W{1'b1}} << LO);

        if (k == 0) begin : g_first
            // Subtraction is X + ~Y + 1, so CI is overridden in that mode.
            assign op_x[k]     = X;
            assign op_y[k]     = SUB ? ~Y : Y;
            assign op_c[k]     = SUB | CI;
            assign sum_prev[k] = '0;
            assign v_in[k]     = I_VALID;
        end else begin : g_rest
            assign op_x[k]     = x_q[k-1];
            assign op_y[k]     = y_q[k-1];
            assign op_c[k]     = c_q[k-1];
            assign sum_prev[k] = s_q[k-1];
            assign v_in[k]     = v_q[k-1];
        end

        assign sum_next[k]   = (sum_prev[k] & ~MASK) | (blk_s & MASK);
        assign stage_co[k]   = g_blk[LAST].co;
        assign unused_ops[k] = ^{op_x[k], op_y[k]};
    end

    for (genvar j = 0; j < NB; j++) begin : g_blk
        localparam int LO = blk_lo(j, BLK);
        localparam int HI = blk_hi(j, BLK, W);
        localparam int K  = j / BPS;

        logic ci;
        logic co;

        // The first block of a stage takes the carry registered by the previous stage.
        if (j % BPS == 0) begin : g_cin_stage
            assign ci = op_c[K];
        end else begin : g_cin_chain
            assign ci = g_blk[j-1].co;
        end

        ubcskb_blk #(.BW(HI - LO + 1)) u_blk (
            .X  (op_x[K][HI:LO]),
            .Y  (op_y[K][HI:LO]),
            .Ci (ci),
            .S  (blk_s[HI:LO]),
            .Co (co)
        );
    end

    assign unused_tail = ^{x_q[STAGES-1], y_q[STAGES-1], unused_ops};

    // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the register arrays are cleared too, so S reads zero straight after reset.
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= op_x[k];
                y_q[k] <= op_y[k];
                s_q[k] <= sum_next[k];
            end
            c_q <= stage_co;
            v_q <= v_in;
        end
    end

endmodule

// File: tb/tb_ubpipe_cska.sv
// Self-checking bench for ubpipe_cska: directed and random traffic on the default
// configuration, plus concurrent random runs over a parameter sweep.
module tb_ubpipe_cska;

    localparam int W   = 27;
    localparam int STG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, i_valid, i_ready, ci, sub, o_valid, o_ready;
    logic [W-1:0] x, y;
    logic [W:0]   s;

    int tests = 0;
    int fails = 0;
    int sweep_done_cnt = 0;

    logic [W:0]  exp_q [$];
    logic [64:0] mon_r;

    ubpipe_cska #(.W(W), .BLK(3), .STAGES(STG)) dut (
        .CLK(clk), .RST(rst), .I_VALID(i_valid), .I_READY(i_ready),
        .X(x), .Y(y), .CI(ci), .SUB(sub),
        .O_VALID(o_valid), .O_READY(o_ready), .S(s)
    );

    // Reference: plain integer arithmetic modulo 2^(w+1); subtraction as X - Y + 2^w.
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                             input logic c, input logic sb, input int w);
        logic [65:0] full;
        logic [65:0] m;
        m = (66'd1 << (w + 1)) - 66'd1;
        if (sb) full = {2'b00, a} + (66'd1 << w) - {2'b00, b};
        else    full = {2'b00, a} + {2'b00, b} + {65'd0, c};
        full = full & m;
        return full[64:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic c, input logic sb);
        i_valid = v;
        x = xv;
        y = yv;
        ci = c;
        sub = sb;
    endtask

    // Scoreboard for the default instance: expectations queued at acceptance, retired in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) check("main_spurious", 128'(o_valid), 128'(1'b0));
                else                   check("main_data", 128'(s), 128'(exp_q.pop_front()));
            end
            if (i_valid && i_ready) begin
                mon_r = ref_sum(64'(x), 64'(y), ci, sub, W);
                exp_q.push_back(mon_r[W:0]);
            end
        end
    end

    task automatic lat_check(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input logic c, input logic sb, input logic [W:0] expv);
        int lat;
        o_ready = 1'b1;
        drive(1'b1, xv, yv, c, sb);
        cyc();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            cyc();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(STG));
        check(tag, 128'(s), 128'(expv));
        cyc();
    endtask

    initial begin
        int vcnt;
        int rises;
        int guard;
        logic prev;
        logic [W:0] held;
        logic [64:0] r;
        logic [W-1:0] ax, ay;

        rst = 1'b1;
        o_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        check("reset_o_valid", 128'(o_valid), 128'(1'b0));
        check("reset_s", 128'(s), 128'(0));
        check("reset_i_ready", 128'(i_ready), 128'(1'b1));

        lat_check("ripple", 27'h7FFFFFF, 27'h0000001, 1'b0, 1'b0, 28'h8000000);
        lat_check("sub_borrow", 27'd5, 27'd7, 1'b0, 1'b1, 28'h7FFFFFE);
        lat_check("sub_noborrow", 27'd7, 27'd5, 1'b1, 1'b1, 28'h8000002);
        lat_check("sub_equal", 27'h1234567, 27'h1234567, 1'b0, 1'b1, 28'h8000000);
        lat_check("add_max_ci", 27'h7FFFFFF, 27'h7FFFFFF, 1'b1, 1'b0, 28'hFFFFFFF);

        // Back-to-back stream of 100 random operations with the output always ready.
        vcnt = 0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 110; i++) begin
            if (i < 100) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            else         i_valid = 1'b0;
            cyc();
            if (o_valid) vcnt++;
            if (o_valid && !prev) rises++;
            prev = o_valid;
        end
        check("b2b_count", 128'(vcnt), 128'(100));
        check("b2b_contiguous", 128'(rises), 128'(1));

        // Backpressure with a full pipe; a fourth operand waits at the input.
        ax = W'($urandom);
        ay = W'($urandom);
        r = ref_sum(64'(ax), 64'(ay), 1'b1, 1'b0, W);
        held = r[W:0];
        drive(1'b1, ax, ay, 1'b1, 1'b0);
        cyc();
        drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
        cyc();
        drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        cyc();
        o_ready = 1'b0;
        drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_i_ready", 128'(i_ready), 128'(1'b0));
            check("bp_o_valid", 128'(o_valid), 128'(1'b1));
            check("bp_hold", 128'(s), 128'(held));
        end
        cyc();
        o_ready = 1'b1;
        cyc();
        i_valid = 1'b0;
        vcnt = 0;
        repeat (8) begin
            if (o_valid) vcnt++;
            cyc();
        end
        check("bp_drain_count", 128'(vcnt), 128'(3));
        check("bp_queue_empty", 128'(exp_q.size()), 128'(0));

        // Reset with three operations in flight.
        o_ready = 1'b0;
        drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
        cyc();
        drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        cyc();
        drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
        cyc();
        check("rst_pipe_full", 128'(o_valid), 128'(1'b1));
        i_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        check("rst_mid_o_valid", 128'(o_valid), 128'(1'b0));
        check("rst_mid_s", 128'(s), 128'(0));
        check("rst_mid_i_ready", 128'(i_ready), 128'(1'b1));
        o_ready = 1'b1;
        vcnt = 0;
        repeat (10) begin
            cyc();
            if (o_valid) vcnt++;
        end
        check("rst_no_stale", 128'(vcnt), 128'(0));

        guard = 0;
        while (sweep_done_cnt < 4 && guard < 5000) begin
            cyc();
            guard++;
        end
        check("sweep_done", 128'(sweep_done_cnt), 128'(4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    function automatic int cfg(input int idx, input int field);
        case (idx)
            0:       return (field == 0) ? 8  : (field == 1) ? 3 : 1;
            1:       return (field == 0) ? 16 : (field == 1) ? 4 : 4;
            2:       return (field == 0) ? 27 : (field == 1) ? 5 : 2;
            default: return (field == 0) ? 64 : (field == 1) ? 8 : 3;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int CW = cfg(g, 0);
        localparam int CB = cfg(g, 1);
        localparam int CS = cfg(g, 2);

        logic          srst, siv, sir, sci, ssub, sov, sor;
        logic [CW-1:0] sx, sy;
        logic [CW:0]   ss;
        logic [CW:0]   sq [$];

        ubpipe_cska #(.W(CW), .BLK(CB), .STAGES(CS)) dut (
            .CLK(clk), .RST(srst), .I_VALID(siv), .I_READY(sir),
            .X(sx), .Y(sy), .CI(sci), .SUB(ssub),
            .O_VALID(sov), .O_READY(sor), .S(ss)
        );

        function automatic logic [CW:0] smodel(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                               input logic c, input logic sb);
            logic [64:0] r;
            r = ref_sum(64'(a), 64'(b), c, sb, CW);
            return r[CW:0];
        endfunction

        task automatic new_op();
            logic [63:0] ra, rb;
            int mode;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            mode = $urandom_range(0, 7);
            if (mode == 0) ra = '1;
            if (mode == 1) rb = '1;
            if (mode == 2) rb = ra;
            sx = ra[CW-1:0];
            sy = rb[CW-1:0];
            sci = 1'($urandom);
            ssub = 1'($urandom);
        endtask

        initial begin
            string tag;
            int lat;
            int guard;
            logic accepted;
            logic [CW:0] e;

            tag = $sformatf("cfg%0d", g);
            srst = 1'b1;
            siv = 1'b0;
            sor = 1'b1;
            sx = '0;
            sy = '0;
            sci = 1'b0;
            ssub = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            srst = 1'b0;
            check({tag, "_reset_s"}, 128'(ss), 128'(0));
            check({tag, "_reset_o_valid"}, 128'(sov), 128'(1'b0));

            new_op();
            e = smodel(sx, sy, sci, ssub);
            siv = 1'b1;
            @(posedge clk);
            #1;
            siv = 1'b0;
            lat = 1;
            while (!sov && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check({tag, "_latency"}, 128'(lat), 128'(CS));
            check({tag, "_first"}, 128'(ss), 128'(e));
            @(posedge clk);
            #1;

            accepted = 1'b0;
            for (int i = 0; i < 200; i++) begin
                sor = ($urandom_range(0, 3) != 0);
                if (!siv || accepted) begin
                    new_op();
                    siv = ($urandom_range(0, 3) != 0);
                end
                @(negedge clk);
                accepted = siv && sir;
                if (sov && sor) begin
                    if (sq.size() == 0) check({tag, "_spurious"}, 128'(sov), 128'(1'b0));
                    else                check({tag, "_data"}, 128'(ss), 128'(sq.pop_front()));
                end
                if (accepted) sq.push_back(smodel(sx, sy, sci, ssub));
                @(posedge clk);
                #1;
            end

            siv = 1'b0;
            sor = 1'b1;
            guard = 0;
            while (sq.size() > 0 && guard < 50) begin
                @(negedge clk);
                if (sov) check({tag, "_drain"}, 128'(ss), 128'(sq.pop_front()));
                @(posedge clk);
                #1;
                guard++;
            end
            check({tag, "_drained"}, 128'(sq.size()), 128'(0));
            sweep_done_cnt++;
        end
    end

endmodule
